trace_writer: RTL

- Capture side of the PIFO trace format; the inverse of the trace reader.
- Samples the push-port stream of a vPIFO tree each enabled cycle and encodes it into trace entries: {1, priority, tree_id, data} for pushes, {0, idle_value} for runs of non-push cycles.
- Buffers entries in a small output FIFO drained by a valid/ready consumer, such as a trace RAM writer or a host DMA.
- A run of R non-push cycles encodes as idle_value = R-1, so replaying the trace through the reader reproduces the push/non-push cycle pattern.

---
 rtl/trace_writer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/trace_writer.sv
// trace_writer: capture side of the PIFO trace format.
// Samples a vPIFO push-port stream on each enabled cycle and encodes it as
// trace entries:
//   push entry : {1, priority, tree_id, data}
//   idle entry : {0, R-1}   for a run of R enabled non-push cycles
// Entries are queued in a small first-word-fall-through FIFO drained by a
// valid/ready consumer.
// Optional feature macro: TRACE_WRITER_STATS_EN adds saturating counters
// o_push_cnt, o_idle_cnt and o_drop_cnt.
// Ports:
//   i_clk, i_arst_n              clock, asynchronous active-low reset
//   i_en                         capture enable (i_en=0 cycles are invisible)
//   i_push, i_push_priority,
//   i_push_tree_id, i_push_data  traced push port
//   i_flush                      close the pending idle run
//   o_trace_valid, o_trace_data,
//   i_trace_ready                FIFO head, valid/ready handshake
//   o_overflow                   sticky: an event was dropped
//   o_busy                       FIFO non-empty or idle run pending
module trace_writer #(
    parameter int unsigned PTW       = 16,
    parameter int unsigned TREE_NUM  = 4,
    parameter int unsigned MTW       = $clog2(TREE_NUM),
    parameter int unsigned CTW       = 10,
    parameter int unsigned FIFO_SIZE = 8,
    parameter int unsigned IDLECYCLE = 1024,
    localparam int unsigned TREE_NUM_BITS   = $clog2(TREE_NUM),
    localparam int unsigned PUSH_BITS       = 2*PTW + TREE_NUM_BITS + MTW,
    localparam int unsigned TRACE_DATA_BITS = ((IDLECYCLE > PUSH_BITS) ? IDLECYCLE : PUSH_BITS) + 1
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic                       i_en,
    input  logic                       i_push,
    input  logic [PTW-1:0]             i_push_priority,
    input  logic [TREE_NUM_BITS-1:0]   i_push_tree_id,
    input  logic [MTW+PTW-1:0]         i_push_data,
    input  logic                       i_flush,
    output logic                       o_trace_valid,
    output logic [TRACE_DATA_BITS-1:0] o_trace_data,
    input  logic                       i_trace_ready,
    output logic                       o_overflow,
    output logic                       o_busy
`ifdef TRACE_WRITER_STATS_EN
    ,
    output logic [CTW-1:0]             o_push_cnt,
    output logic [CTW-1:0]             o_idle_cnt,
    output logic [CTW-1:0]             o_drop_cnt
`endif
);

    localparam int unsigned IDLECYCLE_BITS = $clog2(IDLECYCLE);
    localparam int unsigned RUN_W          = IDLECYCLE_BITS + 1;
    localparam int unsigned DATA_W         = MTW + PTW;
    localparam int unsigned PRIO_W         = TRACE_DATA_BITS - 1 - DATA_W - TREE_NUM_BITS;
    localparam int unsigned PTR_W          = $clog2(FIFO_SIZE);
    localparam int unsigned CNT_W          = PTR_W + 1;

    // Elaboration-time parameter sanity checks
    if (CTW < 1) begin : g_bad_ctw
        $error("trace_writer: CTW must be >= 1");
    end
    if (FIFO_SIZE < 2 || (FIFO_SIZE & (FIFO_SIZE - 1)) != 0) begin : g_bad_fifo
        $error("trace_writer: FIFO_SIZE must be a power of two >= 2");
    end
    if (MTW < TREE_NUM_BITS) begin : g_bad_mtw
        $error("trace_writer: MTW must be >= TREE_NUM_BITS");
    end

    // Stage 1: input registers
    logic                     en_q, push_q, flush_q;
    logic [PTW-1:0]           prio_q;
    logic [TREE_NUM_BITS-1:0] tree_q;
    logic [DATA_W-1:0]        data_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            en_q    <= 1'b0;
            push_q  <= 1'b0;
            flush_q <= 1'b0;
            prio_q  <= '0;
            tree_q  <= '0;
            data_q  <= '0;
        end else begin
            en_q    <= i_en;
            push_q  <= i_push;
            flush_q <= i_flush;
            prio_q  <= i_push_priority;
            tree_q  <= i_push_tree_id;
            data_q  <= i_push_data;
        end
    end

    function automatic logic [TRACE_DATA_BITS-1:0] idle_entry(input logic [RUN_W-1:0] v);
        return {1'b0, (TRACE_DATA_BITS-1)'(v)};
    endfunction

    // Stage 2: encoder, produces up to two entries (idle first) per event
    logic [RUN_W-1:0]           r_q, r_next, r_inc;
    logic [1:0]                 n_wr;
    logic [TRACE_DATA_BITS-1:0] ent0, ent1, push_ent;

    always_comb begin
        n_wr     = 2'd0;
        ent0     = '0;
        ent1     = '0;
        r_next   = r_q;
        r_inc    = r_q + RUN_W'(1);
        push_ent = {1'b1, PRIO_W'(prio_q), tree_q, data_q};
        if (en_q) begin
            if (push_q) begin
                r_next = '0;
                if (r_q != '0) begin
                    n_wr = 2'd2;
                    ent0 = idle_entry(r_q - RUN_W'(1));
                    ent1 = push_ent;
                end else begin
                    n_wr = 2'd1;
                    ent0 = push_ent;
                end
            end else if (r_inc == RUN_W'(IDLECYCLE) || flush_q) begin
                // Run closed by saturation or flush: value is r_inc-1 = r_q
                n_wr   = 2'd1;
                ent0   = idle_entry(r_q);
                r_next = '0;
            end else begin
                r_next = r_inc;
            end
        end
    end

    // FIFO control: a same-cycle pop frees its slot for this cycle's writes
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_p1;
    logic [CNT_W-1:0] cnt_q, cnt_next, free_slots;
    logic             valid_q, pop, accept, drop;
    logic [1:0]       wr_cnt;

    always_comb begin
        pop        = valid_q & i_trace_ready;
        free_slots = CNT_W'(FIFO_SIZE) - cnt_q + CNT_W'(pop);
        accept     = (n_wr != 2'd0) && (CNT_W'(n_wr) <= free_slots);
        drop       = (n_wr != 2'd0) && !accept;
        wr_cnt     = accept ? n_wr : 2'd0;
        cnt_next   = cnt_q + CNT_W'(wr_cnt) - CNT_W'(pop);
        wr_ptr_p1  = wr_ptr_q + PTR_W'(1);
    end

    // FIFO state, run counter and status flags
    logic ovf_q, busy_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            r_q      <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(wr_cnt);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            cnt_q    <= cnt_next;
            valid_q  <= (cnt_next != '0);
            r_q      <= r_next;
            ovf_q    <= ovf_q | drop;
            busy_q   <= (cnt_next != '0) || (r_next != '0);
        end
    end

    // Entry storage; contents are don't-care while the slot is free
    logic [TRACE_DATA_BITS-1:0] mem [FIFO_SIZE];

    always_ff @(posedge i_clk) begin
        if (wr_cnt != 2'd0) begin
            mem[wr_ptr_q] <= ent0;
        end
        if (wr_cnt == 2'd2) begin
            mem[wr_ptr_p1] <= ent1;
        end
    end

    assign o_trace_valid = valid_q;
    assign o_trace_data  = valid_q ? mem[rd_ptr_q] : '0;
    assign o_overflow    = ovf_q;
    assign o_busy        = busy_q;

`ifdef TRACE_WRITER_STATS_EN
    // Saturating event counters
    logic wrote_push, wrote_idle;

    assign wrote_push = accept & push_q;
    assign wrote_idle = accept & ((n_wr == 2'd2) | ~push_q);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_push_cnt <= '0;
            o_idle_cnt <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (wrote_push && o_push_cnt != '1) o_push_cnt <= o_push_cnt + CTW'(1);
            if (wrote_idle && o_idle_cnt != '1) o_idle_cnt <= o_idle_cnt + CTW'(1);
            if (drop && o_drop_cnt != '1)       o_drop_cnt <= o_drop_cnt + CTW'(1);
        end
    end
`endif

endmodule
